pc_reg_redirect: RTL and testbench



---
 rtl/pc_reg_redirect.sv | 170 +++++++++++++++++
 tb/tb_pc_reg_redirect.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_reg_redirect.sv
// pc_reg_redirect
// ----------------------------------------------------------------------------
// Program-counter stage at the head of the MIPS pipeline. Holds the fetch
// address and the instruction-memory enable, and redirects fetch on a
// branch/jump from ID or on an exception/eret flush. A branch raised while the
// fetch stage is stalled is latched and applied on the first unstalled edge.
//
// Ports:
//   clock            in   sole clock, rising-edge
//   reset            in   synchronous, active-high
//   stall            in   pipeline stall vector, bit 0 holds the PC
//   flush            in   exception/eret redirect request
//   flush_target     in   flush destination
//   branch_valid     in   taken branch/jump pulse from ID
//   branch_target    in   branch destination
//   program_counter  out  current fetch address
//   chip_enable      out  instruction memory enable
//   branch_pending   out  a stalled redirect is waiting for stall release
//   misaligned_fault out  one-cycle pulse when a misaligned target is used
//
// Optional feature macro: PC_REG_ALIGN_CHECK_EN
//   defined   : a used target with nonzero low ALIGN_BITS sends the PC to
//               FAULT_VECTOR and pulses misaligned_fault
//   undefined : low ALIGN_BITS of targets are masked, misaligned_fault is 0
// ----------------------------------------------------------------------------
module pc_reg_redirect #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    ALIGN_BITS   = 2,
    parameter int                    STALL_WIDTH  = 6,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_WIDTH-1:0] FAULT_VECTOR = 32'h0000_0180
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [STALL_WIDTH-1:0] stall,
    input  logic                   flush,
    input  logic [ADDR_WIDTH-1:0]  flush_target,
    input  logic                   branch_valid,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic [ADDR_WIDTH-1:0]  program_counter,
    output logic                   chip_enable,
    output logic                   branch_pending,
    output logic                   misaligned_fault
);

    localparam logic [ADDR_WIDTH-1:0] STEP     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << ALIGN_BITS;
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = STEP - 1'b1;

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    pending_q, pending_d;
    logic [ADDR_WIDTH-1:0]   pend_tgt_q, pend_tgt_d;

    // Only stall[0] matters here; the upper bits belong to later stages.
    logic unused_stall_bits;
    assign unused_stall_bits = ^stall;

    // Selected redirect for this edge, resolved into a PC (or a fault) below.
    logic                    take_redirect;
    logic [ADDR_WIDTH-1:0]   redirect_addr;

`ifdef PC_REG_ALIGN_CHECK_EN
    logic fault_q, fault_d;
`endif

    // Next-state and next-PC selection. Priority in RUN is flush, stall,
    // fresh branch, latched branch, then sequential increment.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_d     = pending_q;
        pend_tgt_d    = pend_tgt_q;
        take_redirect = 1'b0;
        redirect_addr = '0;
`ifdef PC_REG_ALIGN_CHECK_EN
        fault_d       = 1'b0;
`endif

        case (state_q)
            OFF: begin
                // First enabled fetch must come from RESET_VECTOR, so the PC
                // is not advanced on the enabling edge.
                state_d    = RUN;
                pc_d       = RESET_VECTOR;
                pending_d  = 1'b0;
                pend_tgt_d = '0;
            end
            RUN: begin
                if (flush) begin
                    take_redirect = 1'b1;
                    redirect_addr = flush_target;
                    pending_d     = 1'b0;
                end else if (stall[0]) begin
                    if (branch_valid) begin
                        // Keep the raw target when alignment is checked so a
                        // misaligned latched branch faults when it is applied.
                        pending_d = 1'b1;
`ifdef PC_REG_ALIGN_CHECK_EN
                        pend_tgt_d = branch_target;
`else
                        pend_tgt_d = branch_target & ~LOW_MASK;
`endif
                    end
                end else if (branch_valid) begin
                    take_redirect = 1'b1;
                    redirect_addr = branch_target;
                    pending_d     = 1'b0;
                end else if (pending_q) begin
                    take_redirect = 1'b1;
                    redirect_addr = pend_tgt_q;
                    pending_d     = 1'b0;
                end else begin
                    pc_d = pc_q + STEP;
                end

                if (take_redirect) begin
`ifdef PC_REG_ALIGN_CHECK_EN
                    if ((redirect_addr & LOW_MASK) != '0) begin
                        pc_d    = FAULT_VECTOR;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = redirect_addr;
                    end
`else
                    pc_d = redirect_addr & ~LOW_MASK;
`endif
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
    end

    // State registers. Reset discards any pending redirect, even mid-stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= OFF;
            pc_q       <= RESET_VECTOR;
            pending_q  <= 1'b0;
            pend_tgt_q <= '0;
`ifdef PC_REG_ALIGN_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            pend_tgt_q <= pend_tgt_d;
`ifdef PC_REG_ALIGN_CHECK_EN
            fault_q    <= fault_d;
`endif
        end
    end

    assign program_counter = pc_q;
    assign chip_enable     = (state_q == RUN);
    assign branch_pending  = pending_q;
`ifdef PC_REG_ALIGN_CHECK_EN
    assign misaligned_fault = fault_q;
`else
    assign misaligned_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_reg_redirect.sv
// tb_pc_reg_redirect
// ----------------------------------------------------------------------------
// Bench for pc_reg_redirect: directed scenarios followed by random traffic,
// every edge compared against a cycle-level behavioural model of the PC stage.
// ----------------------------------------------------------------------------
module tb_pc_reg_redirect;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] FAULT_VEC = 32'h0000_0180;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_target = '0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] program_counter;
    logic        chip_enable;
    logic        branch_pending;
    logic        misaligned_fault;

    int errorCount = 0;
    int checkCount = 0;

    // Behavioural model of the architectural state
    logic        modelOn      = 1'b0;
    logic [31:0] modelPc      = RESET_VEC;
    logic        modelPending = 1'b0;
    logic [31:0] modelTarget  = '0;
    logic        modelFault   = 1'b0;

    pc_reg_redirect dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .flush_target     (flush_target),
        .branch_valid     (branch_valid),
        .branch_target    (branch_target),
        .program_counter  (program_counter),
        .chip_enable      (chip_enable),
        .branch_pending   (branch_pending),
        .misaligned_fault (misaligned_fault)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Resolve a used target into the PC (or a fault) as the stage would.
    task automatic modelRedirect(input logic [31:0] target);
`ifdef PC_REG_ALIGN_CHECK_EN
        if (target % 4 != 0) begin
            modelPc    = FAULT_VEC;
            modelFault = 1'b1;
        end else begin
            modelPc = target;
        end
`else
        modelPc = target - (target % 4);
`endif
    endtask

    // Drive one cycle of inputs, advance the model, clock the DUT, compare.
    task automatic applyStimulus(input logic rst, input logic [5:0] stl, input logic fl,
                                 input logic [31:0] ft, input logic bv, input logic [31:0] bt);
        reset         = rst;
        stall         = stl;
        flush         = fl;
        flush_target  = ft;
        branch_valid  = bv;
        branch_target = bt;

        modelFault = 1'b0;
        if (rst) begin
            modelOn      = 1'b0;
            modelPc      = RESET_VEC;
            modelPending = 1'b0;
            modelTarget  = '0;
        end else if (!modelOn) begin
            modelOn = 1'b1;
            modelPc = RESET_VEC;
        end else if (fl) begin
            modelRedirect(ft);
            modelPending = 1'b0;
        end else if (stl[0]) begin
            if (bv) begin
                modelPending = 1'b1;
                modelTarget  = bt;
            end
        end else if (bv) begin
            modelRedirect(bt);
            modelPending = 1'b0;
        end else if (modelPending) begin
            modelRedirect(modelTarget);
            modelPending = 1'b0;
        end else begin
            modelPc = modelPc + 32'd4;
        end

        @(posedge clock);
        #1;
        checkOutput("pc", program_counter, modelPc);
        checkOutput("chip_enable", {31'd0, chip_enable}, {31'd0, modelOn});
        checkOutput("branch_pending", {31'd0, branch_pending}, {31'd0, modelPending});
        checkOutput("misaligned_fault", {31'd0, misaligned_fault}, {31'd0, modelFault});
    endtask

    task automatic idle();
        applyStimulus(1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] ft;
        logic [31:0] bt;

        $display("[TB] start");

        // Reset for three cycles, then release and run unstalled
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("reset_ce", {31'd0, chip_enable}, 32'd0);
        checkOutput("reset_pc", program_counter, 32'h0);
        idle();
        checkOutput("first_fetch_ce", {31'd0, chip_enable}, 32'd1);
        checkOutput("first_fetch_pc", program_counter, 32'h0);
        idle();
        checkOutput("seq_pc_4", program_counter, 32'h4);
        idle();
        idle();
        checkOutput("seq_pc_c", program_counter, 32'hC);
        idle();
        checkOutput("seq_pc_10", program_counter, 32'h10);

        // Branch from 0x10 to 0x400
        applyStimulus(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 32'h400);
        checkOutput("branch_pc", program_counter, 32'h400);
        idle();
        checkOutput("branch_next", program_counter, 32'h404);

        // Stall three cycles with two branches; the newer target wins
        applyStimulus(1'b0, 6'd1, 1'b0, 32'd0, 1'b1, 32'h200);
        applyStimulus(1'b0, 6'd1, 1'b0, 32'd0, 1'b1, 32'h300);
        applyStimulus(1'b0, 6'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("stall_hold_pc", program_counter, 32'h404);
        checkOutput("stall_pending", {31'd0, branch_pending}, 32'd1);
        idle();
        checkOutput("stall_release_pc", program_counter, 32'h300);
        checkOutput("stall_release_pend", {31'd0, branch_pending}, 32'd0);

        // Flush overrides a pending branch during stall
        applyStimulus(1'b0, 6'd1, 1'b0, 32'd0, 1'b1, 32'h200);
        applyStimulus(1'b0, 6'd1, 1'b1, 32'h180, 1'b0, 32'd0);
        checkOutput("flush_pc", program_counter, 32'h180);
        checkOutput("flush_pend", {31'd0, branch_pending}, 32'd0);

        // Wrap from the top aligned address
        applyStimulus(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
        idle();
        checkOutput("wrap_pc", program_counter, 32'h0);

        // Misaligned branch target
        applyStimulus(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 32'h402);
`ifdef PC_REG_ALIGN_CHECK_EN
        checkOutput("misalign_pc", program_counter, FAULT_VEC);
        checkOutput("misalign_fault", {31'd0, misaligned_fault}, 32'd1);
        idle();
        checkOutput("misalign_pulse_end", {31'd0, misaligned_fault}, 32'd0);
`else
        checkOutput("misalign_pc", program_counter, 32'h400);
        checkOutput("misalign_fault", {31'd0, misaligned_fault}, 32'd0);
`endif

        // Reset while a branch is pending discards it
        applyStimulus(1'b0, 6'd1, 1'b0, 32'd0, 1'b1, 32'h800);
        applyStimulus(1'b1, 6'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("reset_pend_cleared", {31'd0, branch_pending}, 32'd0);
        idle();
        idle();
        checkOutput("reset_pend_seq", program_counter, 32'h4);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            ft = $urandom;
            bt = $urandom;
            if ($urandom_range(3, 0) != 0) ft[1:0] = 2'b00;
            if ($urandom_range(3, 0) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(7, 0) == 0) bt = 32'hFFFF_FFF0 | (bt & 32'hF);
            applyStimulus(($urandom_range(39, 0) == 0),
                          6'($urandom_range(63, 0)) & {5'h1F, ($urandom_range(2, 0) == 0)},
                          ($urandom_range(9, 0) == 0), ft,
                          ($urandom_range(3, 0) == 0), bt);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
